// File: rtl/lift_shaft_model_if.sv
// Motor command / position sensor bundle between a lift controller and the shaft model.
interface lift_shaft_model_if #(
    parameter int unsigned POS_W = 6
);
    logic             enable;
    logic             direction;
    logic             fault_clear;
    logic             bottom;
    logic             middle_minus;
    logic             middle_plus;
    logic             top;
    logic [POS_W-1:0] position;
    logic             moving;
    logic             fault;

    modport master (
        output enable, direction, fault_clear,
        input  bottom, middle_minus, middle_plus, top, position, moving, fault
    );

    modport slave (
        input  enable, direction, fault_clear,
        output bottom, middle_minus, middle_plus, top, position, moving, fault
    );
endinterface

// File: rtl/lift_shaft_model.sv
// Synthesisable lift shaft plant: turns active-low motor commands into shaft position
// and active-low floor sensors, with a sticky fault for driving into an end limit.
module lift_shaft_model #(
    parameter int unsigned STEP_DIV    = 4,
    parameter int unsigned FLOOR_STEPS = 16,
    parameter int unsigned MID_TOL     = 2,
    parameter int unsigned POS_W       = 6
) (
    input  logic               clock,
    input  logic               n_reset,
    lift_shaft_model_if.slave  shaft
);
    localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [POS_W-1:0] POS_ZERO = POS_W'(0);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] MID      = POS_W'(FLOOR_STEPS);
    localparam logic [POS_W-1:0] MID_LO   = POS_W'(FLOOR_STEPS - MID_TOL);
    localparam logic [POS_W-1:0] MID_HI   = POS_W'(FLOOR_STEPS + MID_TOL);
    localparam logic [POS_W-1:0] TOPPOS   = POS_W'(2 * FLOOR_STEPS);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [PRE_W-1:0] prescaler, prescaler_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic             dir_prev;
    logic             fault_q, fault_nxt;
    logic             moving_q, moving_nxt;
    logic             bottom_q, middle_minus_q, middle_plus_q, top_q;

    logic run, reversal, blocked, step;

    // Step timing: a reversal while running restarts the period instead of stepping.
    always_comb begin
        run      = ~shaft.enable;
        reversal = run && (shaft.direction != dir_prev);
        blocked  = shaft.direction ? (pos == TOPPOS) : (pos == POS_ZERO);
        step     = run && !reversal && (prescaler == PRE_LAST);
    end

    always_comb begin
        prescaler_nxt = prescaler + PRE_ONE;
        pos_nxt       = pos;
        fault_nxt     = fault_q;
        moving_nxt    = run && !blocked;

        if (!run || reversal || step) begin
            prescaler_nxt = PRE_ZERO;
        end

        if (step && !blocked) begin
            pos_nxt = shaft.direction ? (pos + POS_ONE) : (pos - POS_ONE);
        end

        // A new limit violation overrides a coincident clear.
        if (step && blocked) begin
            fault_nxt = 1'b1;
        end else if (shaft.fault_clear) begin
            fault_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            prescaler <= PRE_ZERO;
            pos       <= POS_ZERO;
            dir_prev  <= 1'b0;
            fault_q   <= 1'b0;
            moving_q  <= 1'b0;
        end else begin
            prescaler <= prescaler_nxt;
            pos       <= pos_nxt;
            dir_prev  <= shaft.direction;
            fault_q   <= fault_nxt;
            moving_q  <= moving_nxt;
        end
    end

    // Sensors follow the position register one cycle later, like a real switch pickup.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            bottom_q       <= 1'b0;
            middle_minus_q <= 1'b1;
            middle_plus_q  <= 1'b1;
            top_q          <= 1'b1;
        end else begin
            bottom_q       <= !(pos == POS_ZERO);
            middle_minus_q <= !((pos >= MID_LO) && (pos <= MID));
            middle_plus_q  <= !((pos >= MID) && (pos <= MID_HI));
            top_q          <= !(pos == TOPPOS);
        end
    end

    assign shaft.position     = pos;
    assign shaft.fault        = fault_q;
    assign shaft.moving       = moving_q;
    assign shaft.bottom       = bottom_q;
    assign shaft.middle_minus = middle_minus_q;
    assign shaft.middle_plus  = middle_plus_q;
    assign shaft.top          = top_q;
endmodule

// File: tb/tb_lift_shaft_model.sv
// Bench for lift_shaft_model: behavioural shaft model compared every cycle, plus
// directed scenarios with literal expectations and a simple closed-loop controller.
module tb_lift_shaft_model;
    localparam int STEP_DIV    = 4;
    localparam int FLOOR_STEPS = 16;
    localparam int MID_TOL     = 2;
    localparam int POS_W       = 6;
    localparam int MID         = FLOOR_STEPS;
    localparam int TOPPOS      = 2 * FLOOR_STEPS;

    logic clock;
    logic n_reset;

    lift_shaft_model_if #(.POS_W(POS_W)) shaft ();

    lift_shaft_model #(
        .STEP_DIV   (STEP_DIV),
        .FLOOR_STEPS(FLOOR_STEPS),
        .MID_TOL    (MID_TOL),
        .POS_W      (POS_W)
    ) dut (
        .clock  (clock),
        .n_reset(n_reset),
        .shaft  (shaft.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Model: the motor advances one step after STEP_DIV consecutive running cycles in an
    // unchanged direction; sensors report where the shaft was one cycle earlier.
    int m_pos, m_run_cnt, m_sensed_pos;
    bit m_dir_prev, m_fault, m_moving;

    always @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            m_pos        = 0;
            m_run_cnt    = 0;
            m_sensed_pos = 0;
            m_dir_prev   = 1'b0;
            m_fault      = 1'b0;
            m_moving     = 1'b0;
        end else begin
            automatic bit running = (shaft.enable == 1'b0);
            automatic bit up      = (shaft.direction == 1'b1);
            automatic bit at_end  = up ? (m_pos == TOPPOS) : (m_pos == 0);
            automatic bit stepped = 1'b0;

            m_sensed_pos = m_pos;
            m_moving     = running && !at_end;

            if (!running || (up != m_dir_prev)) begin
                m_run_cnt = 0;
            end else begin
                m_run_cnt++;
                if (m_run_cnt == STEP_DIV) begin
                    m_run_cnt = 0;
                    stepped   = 1'b1;
                end
            end

            if (stepped && !at_end) m_pos = up ? m_pos + 1 : m_pos - 1;
            if (stepped && at_end) m_fault = 1'b1;
            else if (shaft.fault_clear) m_fault = 1'b0;
            m_dir_prev = up;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        check("position",     32'(shaft.position),     32'(m_pos));
        check("moving",       32'(shaft.moving),       32'(m_moving));
        check("fault",        32'(shaft.fault),        32'(m_fault));
        check("bottom",       32'(shaft.bottom),       32'(m_sensed_pos != 0));
        check("top",          32'(shaft.top),          32'(m_sensed_pos != TOPPOS));
        check("middle_minus", 32'(shaft.middle_minus),
              32'(!(m_sensed_pos >= MID - MID_TOL && m_sensed_pos <= MID)));
        check("middle_plus",  32'(shaft.middle_plus),
              32'(!(m_sensed_pos >= MID && m_sensed_pos <= MID + MID_TOL)));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit saw_fault;
    bit saw_mid;
    bit reached_top;

    initial begin
        n_reset           = 1'b0;
        shaft.enable      = 1'b1;
        shaft.direction   = 1'b1;
        shaft.fault_clear = 1'b0;
        tick(2);
        check("rst_position",     32'(shaft.position),     0);
        check("rst_bottom",       32'(shaft.bottom),       0);
        check("rst_middle_minus", 32'(shaft.middle_minus), 1);
        check("rst_middle_plus",  32'(shaft.middle_plus),  1);
        check("rst_top",          32'(shaft.top),          1);
        check("rst_fault",        32'(shaft.fault),        0);
        check("rst_moving",       32'(shaft.moving),       0);

        // Run up from floor 0.
        n_reset = 1'b1;
        tick(1);
        shaft.enable = 1'b0;
        tick(3);
        check("up_pre_first_step", 32'(shaft.position), 0);
        tick(1);
        check("up_first_step", 32'(shaft.position), 1);
        check("up_moving",     32'(shaft.moving),   1);
        tick(60);
        check("up_pos16",      32'(shaft.position),     16);
        check("up15_mid_minus", 32'(shaft.middle_minus), 0);
        check("up15_mid_plus",  32'(shaft.middle_plus),  1);
        tick(1);
        check("at16_mid_minus", 32'(shaft.middle_minus), 0);
        check("at16_mid_plus",  32'(shaft.middle_plus),  0);
        tick(63);
        check("up_pos32", 32'(shaft.position), 32);
        tick(1);
        check("top_sensor", 32'(shaft.top), 0);
        tick(3);
        check("top_fault",      32'(shaft.fault),    1);
        check("top_saturate",   32'(shaft.position), 32);
        check("top_not_moving", 32'(shaft.moving),   0);

        shaft.enable      = 1'b1;
        shaft.fault_clear = 1'b1;
        tick(1);
        check("fault_cleared", 32'(shaft.fault), 0);
        shaft.fault_clear = 1'b0;

        // Down two steps, then a partial up period and a reversal back down.
        shaft.direction = 1'b0;
        tick(1);
        shaft.enable = 1'b0;
        tick(8);
        check("down_pos30", 32'(shaft.position), 30);
        shaft.direction = 1'b1;
        tick(3);
        check("partial_up_no_step", 32'(shaft.position), 30);
        shaft.direction = 1'b0;
        tick(4);
        check("reversal_no_step", 32'(shaft.position), 30);
        tick(1);
        check("reversal_step", 32'(shaft.position), 29);

        // Stop mid-period, then restart needs a full period.
        tick(2);
        shaft.enable = 1'b1;
        tick(1);
        check("stop_pos",    32'(shaft.position), 29);
        check("stop_moving", 32'(shaft.moving),   0);
        shaft.enable = 1'b0;
        tick(3);
        check("restart_no_step", 32'(shaft.position), 29);
        tick(1);
        check("restart_step", 32'(shaft.position), 28);

        // Down to the bottom limit; a clear coinciding with a violation loses.
        tick(112);
        check("bottom_pos", 32'(shaft.position), 0);
        tick(1);
        check("bottom_sensor",     32'(shaft.bottom), 0);
        check("bottom_not_moving", 32'(shaft.moving), 0);
        tick(2);
        shaft.fault_clear = 1'b1;
        tick(1);
        check("set_wins_over_clear", 32'(shaft.fault), 1);
        shaft.enable = 1'b1;
        tick(1);
        check("clear_after_set", 32'(shaft.fault), 0);
        shaft.fault_clear = 1'b0;

        // Closed loop: a call to floor 2 runs up past floor 1 and stops on the top sensor.
        shaft.direction = 1'b1;
        tick(1);
        shaft.enable = 1'b0;
        saw_fault   = 1'b0;
        saw_mid     = 1'b0;
        reached_top = 1'b0;
        for (int k = 0; k < 300 && !reached_top; k++) begin
            @(negedge clock);
            if (shaft.fault) saw_fault = 1'b1;
            if (!shaft.middle_minus && !shaft.middle_plus) saw_mid = 1'b1;
            if (!shaft.top) begin
                shaft.enable = 1'b1;
                reached_top  = 1'b1;
            end
        end
        check("cl_reached_top", 32'(reached_top), 1);
        check("cl_passed_mid",  32'(saw_mid),     1);
        tick(6);
        check("cl_stop_pos",   32'(shaft.position), 32);
        check("cl_top_sensor", 32'(shaft.top),      0);
        check("cl_no_fault",   32'(saw_fault | shaft.fault), 0);
        check("cl_stopped",    32'(shaft.moving),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
